// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port BIP data memory. It serves the CPU and the UART
// debug port, and the CPU wins by default. Define DM_ARB_ROUND_ROBIN_EN for strict alternation.
module dm_arbiter #(
  parameter int unsigned DATA_LENGTH = 16,
  parameter int unsigned ADDR_LENGTH = 11,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cpu_req,
  input  logic                   i_cpu_we,
  input  logic [ADDR_LENGTH-1:0] i_cpu_addr,
  input  logic [DATA_LENGTH-1:0] i_cpu_wdata,
  output logic                   o_cpu_gnt,
  output logic                   o_cpu_rvalid,
  output logic [DATA_LENGTH-1:0] o_cpu_rdata,
  input  logic                   i_dbg_req,
  input  logic                   i_dbg_we,
  input  logic [ADDR_LENGTH-1:0] i_dbg_addr,
  input  logic [DATA_LENGTH-1:0] i_dbg_wdata,
  output logic                   o_dbg_gnt,
  output logic                   o_dbg_rvalid,
  output logic [DATA_LENGTH-1:0] o_dbg_rdata,
  output logic                   o_mem_en,
  output logic                   o_mem_we,
  output logic [ADDR_LENGTH-1:0] o_mem_addr,
  output logic [DATA_LENGTH-1:0] o_mem_wdata,
  input  logic [DATA_LENGTH-1:0] i_mem_rdata,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StRdWait = 2'd2
  } state_e;

  state_e                 r_state;
  logic                   r_owner_dbg;
  logic                   r_cpu_gnt;
  logic                   r_dbg_gnt;
  logic                   r_cpu_rvalid;
  logic                   r_dbg_rvalid;
  logic [DATA_LENGTH-1:0] r_cpu_rdata;
  logic [DATA_LENGTH-1:0] r_dbg_rdata;
  logic                   r_mem_en;
  logic                   r_mem_we;
  logic [ADDR_LENGTH-1:0] r_mem_addr;
  logic [DATA_LENGTH-1:0] r_mem_wdata;

  logic                   w_any_req;
  logic                   w_dbg_wins;
  logic                   w_sel_we;
  logic [ADDR_LENGTH-1:0] w_sel_addr;
  logic [DATA_LENGTH-1:0] w_sel_wdata;

  assign w_any_req = i_cpu_req | i_dbg_req;

`ifdef DM_ARB_ROUND_ROBIN_EN
  // Under contention, whoever did not own the previous grant goes next.
  logic r_last_dbg;
  assign w_dbg_wins = i_dbg_req & (~i_cpu_req | ~r_last_dbg);
`else
  // Debug takes over once the CPU has won STARVE_MAX times in a row with debug waiting.
  logic [3:0] r_starve_cnt;
  assign w_dbg_wins = i_dbg_req & (~i_cpu_req | (r_starve_cnt == 4'(STARVE_MAX)));
`endif

  assign w_sel_we    = w_dbg_wins ? i_dbg_we    : i_cpu_we;
  assign w_sel_addr  = w_dbg_wins ? i_dbg_addr  : i_cpu_addr;
  assign w_sel_wdata = w_dbg_wins ? i_dbg_wdata : i_cpu_wdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_owner_dbg  <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      r_last_dbg   <= 1'b1;
`else
      r_starve_cnt <= '0;
`endif
    end else begin
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      case (r_state)
        StIdle: begin
`ifndef DM_ARB_ROUND_ROBIN_EN
          if (!i_dbg_req || w_dbg_wins) begin
            r_starve_cnt <= '0;
          end else if (r_starve_cnt != 4'(STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
          end
`endif
          if (w_any_req) begin
            r_state     <= StIssue;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_owner_dbg <= w_dbg_wins;
            r_cpu_gnt   <= ~w_dbg_wins;
            r_dbg_gnt   <= w_dbg_wins;
`ifdef DM_ARB_ROUND_ROBIN_EN
            r_last_dbg  <= w_dbg_wins;
`endif
          end
        end
        StIssue: begin
          r_state <= r_mem_we ? StIdle : StRdWait;
        end
        StRdWait: begin
          // Memory output is valid now; capture it so rvalid lands with the return to idle.
          if (r_owner_dbg) begin
            r_dbg_rdata  <= i_mem_rdata;
            r_dbg_rvalid <= 1'b1;
          end else begin
            r_cpu_rdata  <= i_mem_rdata;
            r_cpu_rvalid <= 1'b1;
          end
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cpu_gnt    = r_cpu_gnt;
  assign o_dbg_gnt    = r_dbg_gnt;
  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_dbg_rvalid = r_dbg_rvalid;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_dbg_rdata  = r_dbg_rdata;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = (r_state != StIdle);

endmodule
